pipelined_memory: RTL and testbench

PIPELINED_MEMORY -- requirements
Module: pipelined_memory

---
 rtl/pipelined_memory.sv | 146 ++++++++++++++
 tb/tb_pipelined_memory.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_memory.sv
// Single-port byte-addressable memory with fixed request-to-response latency and range/size fault reporting.
// Optional macro PIPELINED_MEMORY_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module pipelined_memory #(
   parameter logic [31:0] START_ADDR = 32'h01000000,
   parameter logic [31:0] MEM_SIZE   = 32'h100000,
   parameter int          LATENCY    = 2,
   parameter string       INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [1:0]  debug_state
);

   // Handshake: a request is taken on an edge with req_valid && req_ready; a response
   // is consumed on an edge with resp_valid && resp_ready. Outputs hold while waiting.

   localparam int WORDS = int'(MEM_SIZE >> 2);
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT  = CW'(LATENCY - 1);
   localparam logic [32:0]   LAST_ADDR = {1'b0, START_ADDR} + {1'b0, MEM_SIZE} - 33'd1;
   localparam logic [31:0]   NOP_WORD  = 32'h00000013;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic            r_we, r_unsigned;
   logic [31:0]     r_addr, r_wdata;
   logic [1:0]      r_size;

   logic [31:0]     mem [WORDS];

   // Memory contents are not part of the reset domain; they start zeroed.
   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = '0;
   end

   logic [2:0]      nbytes;
   logic [32:0]     last_byte;
   logic            misalign, fault, access;
   logic [AW+1:0]   offset;
   logic [AW+1:0]   b_loc [4];
   logic [31:0]     raw, load_data;

   always_comb begin
      nbytes    = 3'd4;
      case (r_size)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
      last_byte = {1'b0, r_addr} + {30'b0, nbytes} - 33'd1;
`ifdef PIPELINED_MEMORY_MISALIGN_TRAP_EN
      misalign  = ((r_size == 2'b01) && r_addr[0]) || ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
`else
      misalign  = 1'b0;
`endif
      fault     = (r_addr < START_ADDR) || (last_byte > LAST_ADDR) || (r_size == 2'b11) || misalign;
      access    = (state == BUSY) && (cnt == '0);
   end

   // Each byte of the access is located independently so misaligned accesses can straddle words.
   always_comb begin
      offset = (AW+2)'(r_addr - START_ADDR);
      raw    = '0;
      for (int i = 0; i < 4; i++) begin
         b_loc[i]       = offset + (AW+2)'(i);
         raw[i*8 +: 8]  = mem[b_loc[i][AW+1:2]][{b_loc[i][1:0], 3'b000} +: 8];
      end
      case (r_size)
         2'b00:   load_data = r_unsigned ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   load_data = r_unsigned ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: load_data = raw;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = BUSY;
         BUSY:    if (cnt == '0) state_nx = RESP;
         RESP:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         r_we       <= 1'b0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_size     <= '0;
         resp_rdata <= '0;
         resp_fault <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            cnt        <= CNT_INIT;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (access) begin
            resp_fault <= fault;
            resp_rdata <= fault ? NOP_WORD : (r_we ? 32'h0 : load_data);
         end
      end
   end

   // Commit happens only on the access edge; an asynchronous reset leaves state IDLE so nothing lands.
   always_ff @(posedge clk) begin
      if (access && r_we && !fault) begin
         for (int i = 0; i < 4; i++) begin
            if (i < int'(nbytes))
               mem[b_loc[i][AW+1:2]][{b_loc[i][1:0], 3'b000} +: 8] <= r_wdata[i*8 +: 8];
         end
      end
   end

   assign req_ready   = (state == IDLE);
   assign resp_valid  = (state == RESP);
   assign debug_state = state;

endmodule

// File: tb/tb_pipelined_memory.sv
// Directed bench for pipelined_memory at default parameters; expectations follow
// PIPELINED_MEMORY_MISALIGN_TRAP_EN when it is defined for the build.
module tb_pipelined_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_ready, resp_fault;
   logic [31:0] resp_rdata;
   logic [1:0]  debug_state;

   int n_vec = 0;
   int n_err = 0;

   pipelined_memory dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_fault   (resp_fault),
      .debug_state  (debug_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rdata, output logic fault, output int lat);
      int wait_n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_size = size; req_unsigned = uns; resp_ready = 1'b0;
      wait_n = 0;
      while (!req_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      if (!req_ready) check("accept_timeout", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      // Scramble inputs after accept: the registered copy must be used.
      req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_unsigned = ~uns;
      lat = 0;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rdata = resp_rdata;
      fault = resp_fault;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic op(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_rdata, input logic exp_fault);
      logic [31:0] rd;
      logic        f;
      int          lat;
      xfer(we, addr, wdata, size, uns, rd, f, lat);
      check({tag, "_lat"}, 32'(lat), 32'd2);
      check({tag, "_rdata"}, rd, exp_rdata);
      check({tag, "_fault"}, {31'b0, f}, {31'b0, exp_fault});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = 2'b10; req_unsigned = 1'b0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_fault", {31'b0, resp_fault}, 32'd0);

      op("st_w",    1'b1, 32'h01000000, 32'hDEADBEEF, 2'b10, 1'b0, 32'h00000000, 1'b0);
      op("ld_w",    1'b0, 32'h01000000, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
      op("ld_b_s",  1'b0, 32'h01000003, 32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 1'b0);
      op("ld_b_u",  1'b0, 32'h01000003, 32'h0,        2'b00, 1'b1, 32'h000000DE, 1'b0);
      op("ld_h_s",  1'b0, 32'h01000002, 32'h0,        2'b01, 1'b0, 32'hFFFFDEAD, 1'b0);
      op("ld_lo",   1'b0, 32'h00FFFFFC, 32'h0,        2'b10, 1'b0, 32'h00000013, 1'b1);
      op("ld_hi",   1'b0, 32'h010FFFFE, 32'h0,        2'b10, 1'b0, 32'h00000013, 1'b1);
      op("ld_top",  1'b0, 32'h010FFFFC, 32'h0,        2'b10, 1'b0, 32'h00000000, 1'b0);
      op("ld_rsv",  1'b0, 32'h01000000, 32'h0,        2'b11, 1'b0, 32'h00000013, 1'b1);
      op("st_lo",   1'b1, 32'h00FFFFFF, 32'h000000AA, 2'b00, 1'b0, 32'h00000013, 1'b1);
      op("st_hi",   1'b1, 32'h010FFFFE, 32'h55667788, 2'b10, 1'b0, 32'h00000013, 1'b1);
      op("ld_top2", 1'b0, 32'h010FFFFC, 32'h0,        2'b10, 1'b0, 32'h00000000, 1'b0);
      op("ld_w2",   1'b0, 32'h01000000, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

`ifdef PIPELINED_MEMORY_MISALIGN_TRAP_EN
      op("st_h_mis", 1'b1, 32'h01000001, 32'h00001234, 2'b01, 1'b0, 32'h00000013, 1'b1);
      op("ld_w3",    1'b0, 32'h01000000, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
      op("ld_h_mis", 1'b0, 32'h01000001, 32'h0,        2'b01, 1'b1, 32'h00000013, 1'b1);
      op("ld_w_mis", 1'b0, 32'h01000002, 32'h0,        2'b10, 1'b0, 32'h00000013, 1'b1);
`else
      op("st_h_mis", 1'b1, 32'h01000001, 32'h00001234, 2'b01, 1'b0, 32'h00000000, 1'b0);
      op("ld_w3",    1'b0, 32'h01000000, 32'h0,        2'b10, 1'b0, 32'hDE1234EF, 1'b0);
      op("ld_h_mis", 1'b0, 32'h01000001, 32'h0,        2'b01, 1'b1, 32'h00001234, 1'b0);
      op("ld_w_mis", 1'b0, 32'h01000002, 32'h0,        2'b10, 1'b0, 32'h0000DE12, 1'b0);
`endif

      // Response back-pressure with a second request waiting.
      begin
         int lat;
         @(negedge clk);
         req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h01000000; req_size = 2'b00;
         req_unsigned = 1'b1; resp_ready = 1'b0;
         @(posedge clk);
         @(negedge clk);
         req_addr = 32'h01000004; req_unsigned = 1'b0;
         lat = 0;
         while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check("stall_lat", 32'(lat), 32'd2);
         for (int k = 0; k < 5; k++) begin
            check("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_rdata", resp_rdata, 32'h000000EF);
            check("stall_fault", {31'b0, resp_fault}, 32'd0);
            check("stall_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
         end
         resp_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         resp_ready = 1'b0; req_valid = 1'b0;
         check("release_resp_valid", {31'b0, resp_valid}, 32'd0);
         check("release_req_ready", {31'b0, req_ready}, 32'd1);
         repeat (4) @(negedge clk);
         check("no_second_accept", {31'b0, resp_valid}, 32'd0);
      end

      // Reset one cycle into a store: nothing may be written.
      op("st_pre", 1'b1, 32'h01000010, 32'h11223344, 2'b10, 1'b0, 32'h00000000, 1'b0);
      op("ld_pre", 1'b0, 32'h01000010, 32'h0,        2'b10, 1'b0, 32'h11223344, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h01000010; req_wdata = 32'hCAFEF00D;
      req_size = 2'b10;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("midrst_rdata", resp_rdata, 32'd0);
      check("midrst_fault", {31'b0, resp_fault}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("postrst_req_ready", {31'b0, req_ready}, 32'd1);
      op("ld_post", 1'b0, 32'h01000010, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
